// File: rtl/gameboard_pkg.sv
// Shared board geometry, game states, button indices and the placement LFSR taps
// used by the minesweeper game-state engine.
package gameboard_pkg;

    localparam int unsigned BOARD_DIM = 8;
    localparam int unsigned CELLS     = 64;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned NUM_BTNS  = 6;

    // Press-vector bit positions, lowest priority first
    localparam int unsigned BTN_RIGHT = 0;
    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_DOWN  = 2;
    localparam int unsigned BTN_UP    = 3;
    localparam int unsigned BTN_FLAG  = 4;
    localparam int unsigned BTN_STEP  = 5;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [1:0] {
        PLACE,
        PLAY,
        LOST,
        WON
    } game_state_e;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/button_pulse.sv
// Per-button conditioner: optional debounce (DEBOUNCE_EN) followed by a registered
// rising-edge detector producing a single-cycle press pulse.
module button_pulse #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic level;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    if (DEBOUNCE_CYCLES == 20'd0) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES must be non-zero");
    end

`ifdef DEBOUNCE_EN
    logic [19:0] cnt_q, cnt_d;
    logic        filt_q, filt_d;

    // Counter runs only while the raw sample disagrees with the filtered level
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (raw != filt_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
                filt_d = raw;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = raw;
`endif

    always_comb begin
        prev_d  = level;
        pulse_d = level & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/board_input_ctrl.sv
// Minesweeper game-state engine: LFSR mine placement, cursor/flag/step handling and
// the redraw request/ack handshake. Define DEBOUNCE_EN to debounce the buttons.
module board_input_ctrl
    import gameboard_pkg::*;
#(
    parameter int unsigned NUM_MINES       = 10,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_flag,
    input  logic        btn_step,
    output logic [63:0] mineMap,
    output logic [63:0] flagMap,
    output logic [63:0] stepMap,
    output logic [2:0]  cursor_x,
    output logic [2:0]  cursor_y,
    output logic        game_over,
    output logic        game_won,
    output logic        redraw_req,
    input  logic        redraw_ack
);

    localparam logic [IDX_W-1:0] MINES_TARGET = IDX_W'(NUM_MINES);
    localparam logic [2:0]       COORD_MAX    = 3'(BOARD_DIM - 1);

    if (NUM_MINES < 1 || NUM_MINES > CELLS - 1) begin : g_bad_num_mines
        $error("NUM_MINES must be in 1..63");
    end
    if (LFSR_SEED == 8'd0) begin : g_bad_seed
        $error("LFSR_SEED must be non-zero");
    end

    logic [NUM_BTNS-1:0] raw_btn;
    logic [NUM_BTNS-1:0] press;

    assign raw_btn = {btn_step, btn_flag, btn_up, btn_down, btn_left, btn_right};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_pulse #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_btn[i]),
            .pulse (press[i])
        );
    end

    game_state_e      state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [IDX_W-1:0] placed_q, placed_d;
    logic [CELLS-1:0] mine_q, mine_d;
    logic [CELLS-1:0] flag_q, flag_d;
    logic [CELLS-1:0] step_q, step_d;
    logic [2:0]       cur_x_q, cur_x_d;
    logic [2:0]       cur_y_q, cur_y_d;
    logic             over_q, over_d;
    logic             won_q, won_d;
    logic             req_q, req_d;

    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] cur;
    logic             board_full;
    logic             change;

    assign cand       = lfsr_q[IDX_W-1:0];
    assign cur        = cell_idx(cur_x_q, cur_y_q);
    assign board_full = &(step_q | mine_q);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        placed_d = placed_q;
        mine_d   = mine_q;
        flag_d   = flag_q;
        step_d   = step_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;

        case (state_q)
            PLACE: begin
                if (!mine_q[cand]) begin
                    mine_d[cand] = 1'b1;
                    placed_d     = placed_q + 6'd1;
                end
                if (placed_d == MINES_TARGET) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // A completed board wins before any press of this cycle is considered
                if (board_full) begin
                    state_d = WON;
                end else if (press[BTN_STEP]) begin
                    if (!flag_q[cur] && !step_q[cur]) begin
                        step_d[cur] = 1'b1;
                        if (mine_q[cur]) begin
                            step_d  = step_d | mine_q;
                            state_d = LOST;
                        end
                    end
                end else if (press[BTN_FLAG]) begin
                    if (!step_q[cur]) begin
                        flag_d[cur] = ~flag_q[cur];
                    end
                end else if (press[BTN_UP]) begin
                    if (cur_y_q != 3'd0) cur_y_d = cur_y_q - 3'd1;
                end else if (press[BTN_DOWN]) begin
                    if (cur_y_q != COORD_MAX) cur_y_d = cur_y_q + 3'd1;
                end else if (press[BTN_LEFT]) begin
                    if (cur_x_q != 3'd0) cur_x_d = cur_x_q - 3'd1;
                end else if (press[BTN_RIGHT]) begin
                    if (cur_x_q != COORD_MAX) cur_x_d = cur_x_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Request rises on the same edge as the visible change, so the renderer never
    // sees an updated board with redraw_req low; a coinciding ack is overridden.
    always_comb begin
        over_d = (state_d == LOST);
        won_d  = (state_d == WON);
        change = (mine_d != mine_q) || (flag_d != flag_q) || (step_d != step_q) ||
                 (cur_x_d != cur_x_q) || (cur_y_d != cur_y_q) ||
                 (over_d != over_q) || (won_d != won_q);
        req_d  = req_q;
        if (change) begin
            req_d = 1'b1;
        end else if (redraw_ack) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PLACE;
            lfsr_q   <= LFSR_SEED;
            placed_q <= '0;
            mine_q   <= '0;
            flag_q   <= '0;
            step_q   <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            over_q   <= 1'b0;
            won_q    <= 1'b0;
            req_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            placed_q <= placed_d;
            mine_q   <= mine_d;
            flag_q   <= flag_d;
            step_q   <= step_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            over_q   <= over_d;
            won_q    <= won_d;
            req_q    <= req_d;
        end
    end

    assign mineMap    = mine_q;
    assign flagMap    = flag_q;
    assign stepMap    = step_q;
    assign cursor_x   = cur_x_q;
    assign cursor_y   = cur_y_q;
    assign game_over  = over_q;
    assign game_won   = won_q;
    assign redraw_req = req_q;

endmodule

// File: tb/tb_board_input_ctrl.sv
// Self-checking bench for board_input_ctrl: placement, cursor table, flag/step table,
// redraw handshake, randomized play against a game model, win and loss sequences.
module tb_board_input_ctrl;

    localparam int         NUM_MINES = 10;
    localparam logic [7:0] SEED      = 8'hA5;

    localparam bit [5:0] M_R = 6'b000001;
    localparam bit [5:0] M_L = 6'b000010;
    localparam bit [5:0] M_D = 6'b000100;
    localparam bit [5:0] M_U = 6'b001000;
    localparam bit [5:0] M_F = 6'b010000;
    localparam bit [5:0] M_S = 6'b100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_up, btn_down, btn_left, btn_right, btn_flag, btn_step;
    logic [63:0] mineMap, flagMap, stepMap;
    logic [2:0]  cursor_x, cursor_y;
    logic        game_over, game_won, redraw_req, redraw_ack;

    always #5 clk = ~clk;

    board_input_ctrl #(
        .NUM_MINES       (NUM_MINES),
        .LFSR_SEED       (SEED),
        .DEBOUNCE_CYCLES (20'd4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_flag   (btn_flag),
        .btn_step   (btn_step),
        .mineMap    (mineMap),
        .flagMap    (flagMap),
        .stepMap    (stepMap),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .game_over  (game_over),
        .game_won   (game_won),
        .redraw_req (redraw_req),
        .redraw_ack (redraw_ack)
    );

    int errors = 0;
    int checks = 0;

    // Game model
    bit [63:0] m_mines, m_flags, m_steps;
    int        m_x, m_y;
    bit        m_over, m_won;

    typedef struct {
        bit [5:0] btn;
        int       ex;
        int       ey;
    } cur_vec_t;

    typedef struct {
        bit [5:0] btn;
        bit       ef;
        bit       es;
    } cell_vec_t;

    cur_vec_t  cur_tab[$];
    cell_vec_t cell_tab[$];

    function automatic cur_vec_t cv(input bit [5:0] b, input int x, input int y);
        cur_vec_t v;
        v.btn = b; v.ex = x; v.ey = y;
        return v;
    endfunction

    function automatic cell_vec_t lv(input bit [5:0] b, input bit f, input bit s);
        cell_vec_t v;
        v.btn = b; v.ef = f; v.es = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit [5:0] m);
        btn_right = m[0];
        btn_left  = m[1];
        btn_down  = m[2];
        btn_up    = m[3];
        btn_flag  = m[4];
        btn_step  = m[5];
    endtask

    // Placement as the rules describe it: walk the LFSR sequence from the seed,
    // one candidate per cycle, until NUM_MINES distinct cells are chosen.
    task automatic model_place(output bit [63:0] mines, output int cycles);
        bit [7:0] r;
        int       n;
        r = SEED; mines = '0; cycles = 0; n = 0;
        while (n < NUM_MINES) begin
            if (!mines[r[5:0]]) begin
                mines[r[5:0]] = 1'b1;
                n++;
            end
            cycles++;
            r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
        end
    endtask

    task automatic model_apply(input bit [5:0] m);
        int c;
        c = m_y * 8 + m_x;
        if (m_over || m_won || m == 0) return;
        if (m[5]) begin
            if (!m_flags[c] && !m_steps[c]) begin
                m_steps[c] = 1'b1;
                if (m_mines[c]) begin
                    m_steps = m_steps | m_mines;
                    m_over  = 1'b1;
                end
            end
        end else if (m[4]) begin
            if (!m_steps[c]) m_flags[c] = !m_flags[c];
        end else if (m[3]) begin
            m_y = (m_y > 0) ? m_y - 1 : 0;
        end else if (m[2]) begin
            m_y = (m_y < 7) ? m_y + 1 : 7;
        end else if (m[1]) begin
            m_x = (m_x > 0) ? m_x - 1 : 0;
        end else begin
            m_x = (m_x < 7) ? m_x + 1 : 7;
        end
        if (!m_over && ((m_steps | m_mines) == {64{1'b1}})) m_won = 1'b1;
    endtask

    task automatic press(input bit [5:0] m);
        @(negedge clk); drive(m);
        @(negedge clk); drive(6'b0);
        @(negedge clk);
        @(negedge clk);
        model_apply(m);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_x"},    cursor_x,  m_x);
        check({tag, "_y"},    cursor_y,  m_y);
        check({tag, "_flag"}, flagMap,   m_flags);
        check({tag, "_step"}, stepMap,   m_steps);
        check({tag, "_over"}, game_over, m_over);
        check({tag, "_won"},  game_won,  m_won);
    endtask

    task automatic goto_cell(input int tx, input int ty);
        while (!m_over && !m_won && m_x < tx) press(M_R);
        while (!m_over && !m_won && m_x > tx) press(M_L);
        while (!m_over && !m_won && m_y < ty) press(M_D);
        while (!m_over && !m_won && m_y > ty) press(M_U);
    endtask

    task automatic do_reset();
        drive(6'b0);
        redraw_ack = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mine", mineMap, 64'd0);
        check("rst_flag", flagMap, 64'd0);
        check("rst_step", stepMap, 64'd0);
        check("rst_cx", cursor_x, 0);
        check("rst_cy", cursor_y, 0);
        check("rst_over", game_over, 0);
        check("rst_won", game_won, 0);
        check("rst_req", redraw_req, 1);
        m_flags = '0; m_steps = '0; m_x = 0; m_y = 0; m_over = 0; m_won = 0;
    endtask

    // Releases reset with flag+step already pressed; those presses land in placement.
    task automatic do_place();
        bit [63:0] exp_m;
        int        exp_cyc, sets, cyc, prev_pc, pc;
        model_place(exp_m, exp_cyc);
        reset = 1'b0;
        drive(M_F | M_S);
        prev_pc = 0; sets = 0; cyc = 0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) drive(6'b0);
            pc = $countones(mineMap);
            if (pc == prev_pc + 1) sets++;
            prev_pc = pc;
            if (pc >= NUM_MINES) break;
        end
        check("place_cycles", cyc, exp_cyc);
        check("place_sets", sets, NUM_MINES);
        check("place_popcount", $countones(mineMap), NUM_MINES);
        check("place_map", mineMap, exp_m);
        repeat (3) @(negedge clk);
        check("place_flag_drop", flagMap, 64'd0);
        check("place_step_drop", stepMap, 64'd0);
        m_mines = exp_m;
    endtask

    task automatic ack_pulse(input string name, input bit exp_req);
        @(negedge clk); redraw_ack = 1'b1;
        @(negedge clk); redraw_ack = 1'b0;
        check(name, redraw_req, exp_req);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    initial begin
        bit [5:0]  m;
        bit [63:0] prev_steps;
        int        tx, ty, c, remaining, safe_i, mine_i;
        bit        found;

        cur_tab.push_back(cv(M_L, 0, 0));
        cur_tab.push_back(cv(M_L, 0, 0));
        cur_tab.push_back(cv(M_L, 0, 0));
        cur_tab.push_back(cv(M_U, 0, 0));
        cur_tab.push_back(cv(M_U, 0, 0));
        for (int i = 1; i <= 9; i++) cur_tab.push_back(cv(M_R, (i > 7) ? 7 : i, 0));
        cur_tab.push_back(cv(M_L, 6, 0));
        cur_tab.push_back(cv(M_L, 5, 0));
        cur_tab.push_back(cv(M_D, 5, 1));
        cur_tab.push_back(cv(M_D, 5, 2));
        cur_tab.push_back(cv(M_U, 5, 1));

        cell_tab.push_back(lv(M_F, 1'b1, 1'b0));
        cell_tab.push_back(lv(M_S, 1'b1, 1'b0));
        cell_tab.push_back(lv(M_F, 1'b0, 1'b0));
        cell_tab.push_back(lv(M_S, 1'b0, 1'b1));
        cell_tab.push_back(lv(M_F, 1'b0, 1'b1));

        do_reset();
        do_place();

        foreach (cur_tab[i]) begin
            press(cur_tab[i].btn);
            check($sformatf("cur_tab%0d_x", i), cursor_x, cur_tab[i].ex);
            check($sformatf("cur_tab%0d_y", i), cursor_y, cur_tab[i].ey);
        end

        // Held right for 100 cycles moves exactly once
        @(negedge clk); drive(M_R);
        repeat (100) @(negedge clk);
        drive(6'b0);
        repeat (3) @(negedge clk);
        model_apply(M_R);
        check("hold_right_x", cursor_x, 6);
        check_model("hold");

        safe_i = 0; found = 0;
        for (int i = 0; i < 64; i++) begin
            if (!found && !m_mines[i]) begin safe_i = i; found = 1; end
        end
        goto_cell(safe_i % 8, safe_i / 8);
        foreach (cell_tab[i]) begin
            press(cell_tab[i].btn);
            check($sformatf("cell_tab%0d_flag", i), flagMap[safe_i], cell_tab[i].ef);
            check($sformatf("cell_tab%0d_step", i), stepMap[safe_i], cell_tab[i].es);
            check_model($sformatf("cell_tab%0d", i));
        end

        ack_pulse("ack_idle_clear", 1'b0);
        ack_pulse("ack_while_low", 1'b0);
        for (int i = 0; i < 3; i++) begin
            press((m_x < 7) ? M_R : M_L);
            check($sformatf("req_hold_move%0d", i), redraw_req, 1);
        end
        m = (m_x < 7) ? M_R : M_L;
        @(negedge clk); drive(m);
        @(negedge clk); drive(6'b0); redraw_ack = 1'b1;
        @(negedge clk); redraw_ack = 1'b0;
        model_apply(m);
        check("req_ack_with_move", redraw_req, 1);
        check_model("ack_move");
        @(negedge clk);
        check("req_after_coalesce", redraw_req, 1);
        ack_pulse("ack_clear", 1'b0);

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) m = 6'($urandom_range(1, 63));
            else m = 6'(1) << $urandom_range(0, 5);
            c = m_y * 8 + m_x;
            if (m[5] && m_mines[c] && !m_flags[c] && !m_steps[c]) m[5] = 1'b0;
            if (m == 0) m = M_F;
            press(m);
            check_model($sformatf("rnd%0d", it));
        end

        remaining = 0;
        for (int i = 0; i < 64; i++) if (!m_mines[i] && !m_steps[i]) remaining++;
        for (int i = 0; i < 64; i++) begin
            if (!m_mines[i] && !m_steps[i] && !m_won) begin
                goto_cell(i % 8, i / 8);
                if (m_flags[i]) press(M_F);
                remaining--;
                if (remaining == 0) check("won_before_last", game_won, 0);
                press(M_S);
            end
        end
        check("win_won", game_won, 1);
        check("win_over", game_over, 0);
        check_model("win");
        press(M_L); press(M_S); press(M_F); press(M_D);
        check_model("won_frozen");

        do_reset();
        do_place();
        safe_i = 0; mine_i = 0; found = 0;
        for (int i = 63; i >= 0; i--) if (!m_mines[i]) safe_i = i;
        for (int i = 63; i >= 0; i--) if (m_mines[i]) mine_i = i;
        goto_cell(safe_i % 8, safe_i / 8);
        press(M_S);
        goto_cell(mine_i % 8, mine_i / 8);
        check_model("pre_loss");
        prev_steps = m_steps;
        @(negedge clk); drive(M_S);
        @(negedge clk); drive(6'b0);
        check("loss_over_early", game_over, 0);
        @(negedge clk);
        check("loss_over", game_over, 1);
        check("loss_reveal", stepMap, prev_steps | m_mines);
        model_apply(M_S);
        @(negedge clk);
        press(M_R); press(M_U); press(M_F); press(M_S);
        check_model("lost_frozen");
        check("lost_step_frozen", stepMap, prev_steps | m_mines);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
